axi_read_arbiter: RTL and testbench

//  Two-master AXI4 read arbiter between i_cache (master I) and d_cache (master D)
//  and the single AXI master port. One outstanding read burst at a time, so R-channel

---
 rtl/axi_pkg.sv | 25 ++
 rtl/axi_read_arbiter_grant.sv | 27 ++
 rtl/axi_read_arbiter.sv | 119 +++++++++++
 tb/tb_axi_read_arbiter.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// Shared constants for the two-master AXI read arbiter: FSM encoding, master IDs,
// fixed AR attributes and AXI response codes.
package axi_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADDR = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;

    localparam int unsigned ID_I = 0;
    localparam int unsigned ID_D = 1;

    localparam logic [2:0] SIZE_4B    = 3'b010;
    localparam logic [1:0] BURST_INCR = 2'b01;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } grant_e;

endpackage

// File: rtl/axi_read_arbiter_grant.sv
// arb_grant2: combinational two-way grant pick between i_cache and d_cache.
// ARB_ROUND_ROBIN_EN selects round-robin on contention; otherwise D wins.
module arb_grant2
    import axi_pkg::*;
(
    input  logic   req_icache_i,
    input  logic   req_dcache_i,
`ifdef ARB_ROUND_ROBIN_EN
    input  grant_e last_grant_i,
`endif
    output grant_e grant_o
);

    always_comb begin
        grant_o = GNT_I;
        if (req_dcache_i && req_icache_i) begin
`ifdef ARB_ROUND_ROBIN_EN
            grant_o = (last_grant_i == GNT_I) ? GNT_D : GNT_I;
`else
            grant_o = GNT_D;
`endif
        end else if (req_dcache_i) begin
            grant_o = GNT_D;
        end
    end

endmodule

// File: rtl/axi_read_arbiter.sv
// Two-master AXI4 read arbiter (i_cache / d_cache), one outstanding burst at a time.
// Optional ARB_ROUND_ROBIN_EN: round-robin on contention instead of fixed D > I.
module axi_read_arbiter
    import axi_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] i_araddr,
    input  logic [7:0]        i_arlen,
    input  logic              i_arvalid,
    output logic              i_arready,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_rlast,
    output logic              i_rvalid,
    input  logic              i_rready,
    input  logic [ADDR_W-1:0] d_araddr,
    input  logic [7:0]        d_arlen,
    input  logic              d_arvalid,
    output logic              d_arready,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_rlast,
    output logic              d_rvalid,
    input  logic              d_rready,
    output logic [1:0]        d_rresp,
    output logic [ID_W-1:0]   arid,
    output logic [ADDR_W-1:0] araddr,
    output logic [7:0]        arlen,
    output logic [2:0]        arsize,
    output logic [1:0]        arburst,
    output logic              arvalid,
    input  logic              arready,
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        rresp,
    input  logic              rlast,
    input  logic              rvalid,
    output logic              rready
);

    logic [1:0] state_q, state_d;
    grant_e     grant_q, grant_d;
    grant_e     pick;
    logic       in_addr, in_data, gnt_d;
    logic       ar_hs, r_done;

`ifdef ARB_ROUND_ROBIN_EN
    grant_e     last_grant_q;
`endif

    arb_grant2 u_grant (
        .req_icache_i (i_arvalid),
        .req_dcache_i (d_arvalid),
`ifdef ARB_ROUND_ROBIN_EN
        .last_grant_i (last_grant_q),
`endif
        .grant_o      (pick)
    );

    assign in_addr = (state_q == ST_ADDR);
    assign in_data = (state_q == ST_DATA);
    assign gnt_d   = (grant_q == GNT_D);
    assign ar_hs   = arvalid && arready;
    assign r_done  = in_data && rvalid && rready && rlast;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        case (state_q)
            ST_IDLE: if (i_arvalid || d_arvalid) begin
                state_d = ST_ADDR;
                grant_d = pick;
            end
            ST_ADDR: if (ar_hs)  state_d = ST_DATA;
            ST_DATA: if (r_done) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            grant_q <= GNT_I;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk) begin
        if (rst)        last_grant_q <= GNT_I;
        else if (ar_hs) last_grant_q <= grant_q;
    end
`endif

    // AR fields are only driven in ADDR so the bus reads zero when idle.
    assign arvalid   = in_addr && (gnt_d ? d_arvalid : i_arvalid);
    assign araddr    = in_addr ? (gnt_d ? d_araddr : i_araddr) : '0;
    assign arlen     = in_addr ? (gnt_d ? d_arlen : i_arlen) : '0;
    assign arid      = in_addr ? (gnt_d ? ID_W'(ID_D) : ID_W'(ID_I)) : '0;
    assign arsize    = SIZE_4B;
    assign arburst   = BURST_INCR;
    assign i_arready = in_addr && !gnt_d && arready;
    assign d_arready = in_addr &&  gnt_d && arready;

    // R routing follows the registered grant; RID is not needed with one burst in flight.
    assign rready    = in_data && (gnt_d ? d_rready : i_rready);
    assign i_rvalid  = in_data && !gnt_d && rvalid;
    assign d_rvalid  = in_data &&  gnt_d && rvalid;
    assign i_rlast   = in_data && !gnt_d && rlast;
    assign d_rlast   = in_data &&  gnt_d && rlast;
    assign i_rdata   = rdata;
    assign d_rdata   = rdata;
    assign d_rresp   = rresp;

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Self-checking bench for axi_read_arbiter: vector table, hand-written corner sequences
// and randomized transaction sets checked against a transaction-level arbitration model.
module tb_axi_read_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] i_araddr, d_araddr, i_rdata, d_rdata, araddr, rdata;
    logic [7:0]  i_arlen, d_arlen, arlen;
    logic        i_arvalid, i_arready, i_rlast, i_rvalid, i_rready;
    logic        d_arvalid, d_arready, d_rlast, d_rvalid, d_rready;
    logic [1:0]  d_rresp, arburst, rresp;
    logic [2:0]  arsize;
    logic [3:0]  arid;
    logic        arvalid, arready, rlast, rvalid, rready;

    int n_tests = 0;
    int n_fail  = 0;
    int last_g  = 0;   // model: master granted at the most recent AR handshake (0=I, 1=D)

    axi_read_arbiter #(.ADDR_W(32), .DATA_W(32), .ID_W(4)) dut (
        .clk(clk), .rst(rst),
        .i_araddr(i_araddr), .i_arlen(i_arlen), .i_arvalid(i_arvalid), .i_arready(i_arready),
        .i_rdata(i_rdata), .i_rlast(i_rlast), .i_rvalid(i_rvalid), .i_rready(i_rready),
        .d_araddr(d_araddr), .d_arlen(d_arlen), .d_arvalid(d_arvalid), .d_arready(d_arready),
        .d_rdata(d_rdata), .d_rlast(d_rlast), .d_rvalid(d_rvalid), .d_rready(d_rready),
        .d_rresp(d_rresp),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int          first_id;
        logic [31:0] first_addr;
        logic [7:0]  first_len;
        int          hs_cyc;
        int          bi;
        int          bd;
        logic [1:0]  last_dresp;
    } res_t;

    typedef struct {
        bit          ri, rd;
        logic [31:0] ai, ad;
        logic [7:0]  li, ld;
        logic [31:0] base;
        logic [1:0]  resp;
        int          e_id;
        logic [31:0] e_addr;
        logic [7:0]  e_len;
        int          e_hs;
        int          e_bi, e_bd;
        logic [1:0]  e_dresp;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        chk(nm, 64'(act), 64'(exp));
    endtask

    // Arbitration rule when both masters are waiting.
    function automatic int model_pick();
`ifdef ARB_ROUND_ROBIN_EN
        return (last_g == 0) ? 1 : 0;
`else
        return 1;
`endif
    endfunction

    task automatic idle_inputs();
        i_arvalid = 0; i_araddr = '0; i_arlen = '0; i_rready = 0;
        d_arvalid = 0; d_araddr = '0; d_arlen = '0; d_rready = 0;
        arready = 0; rdata = '0; rresp = '0; rlast = 0; rvalid = 0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1; idle_inputs();
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 0; last_g = 0;
    endtask

    // Issue one set of requests (I and/or D at the same cycle), act as AXI slave and
    // masters, and check every cycle until all bursts are done plus two idle cycles.
    task automatic run_set(input bit ri, input bit rd,
                           input logic [31:0] ai, input logic [31:0] ad,
                           input logic [7:0] li, input logic [7:0] ld,
                           input logic [31:0] base, input logic [1:0] resp,
                           input bit rnd, output res_t r);
        bit pend_i = ri, pend_d = rd, busy = 0;
        int cur = 0, left = 0, beat = 0, since_done = -1, cyc = 0;
        int order[$];
        logic [31:0] ea;
        logic [7:0]  el;
        r.first_id = -1; r.first_addr = '0; r.first_len = '0; r.hs_cyc = -1;
        r.bi = 0; r.bd = 0; r.last_dresp = '0;
        if (ri && rd) begin
            order.push_back(model_pick());
            order.push_back(1 - order[0]);
        end else if (ri) order.push_back(0);
        else if (rd)     order.push_back(1);
        while ((pend_i || pend_d || busy || since_done >= 0) && cyc < 400) begin
            @(posedge clk); #1;
            i_arvalid = pend_i; i_araddr = ai; i_arlen = li;
            d_arvalid = pend_d; d_araddr = ad; d_arlen = ld;
            arready  = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
            i_rready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            d_rready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            rvalid   = busy && (rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
            rdata    = rnd ? $urandom : base + 32'(beat);
            rlast    = rvalid && (left == 1);
            rresp    = rnd ? 2'($urandom_range(0, 3)) : resp;
            @(negedge clk);
            if (i_rvalid && i_rready) r.bi++;
            if (d_rvalid && d_rready) r.bd++;
            if (since_done >= 0) begin
                since_done++;
                if (since_done == 1) chk1("idle_after_last", arvalid, 0);
                if (since_done == 2) begin
                    chk1("next_ar_after_bubble", arvalid, pend_i || pend_d);
                    since_done = -1;
                end
            end
            if (busy) begin
                chk1("rready_route", rready, cur ? d_rready : i_rready);
                chk1("rvalid_granted", cur ? d_rvalid : i_rvalid, rvalid);
                chk1("rvalid_other", cur ? i_rvalid : d_rvalid, 0);
                if (rvalid && (cur ? d_rready : i_rready)) begin
                    chk("rdata", 64'(cur ? d_rdata : i_rdata), 64'(rdata));
                    chk1("rlast", cur ? d_rlast : i_rlast, rlast);
                    if (cur == 1) chk("d_rresp", 64'(d_rresp), 64'(rresp));
                    left--; beat++;
                    if (left == 0) begin
                        busy = 0; since_done = 0; r.last_dresp = d_rresp;
                    end
                end
            end else begin
                chk1("rready_not_data", rready, 0);
            end
            if (arvalid) begin
                if (order.size() == 0) begin
                    chk1("spurious_arvalid", arvalid, 0);
                end else begin
                    ea = order[0] ? ad : ai;
                    el = order[0] ? ld : li;
                    chk("arid", 64'(arid), 64'(order[0]));
                    chk("araddr", 64'(araddr), 64'(ea));
                    chk("arlen", 64'(arlen), 64'(el));
                    chk1("arready_granted", order[0] ? d_arready : i_arready, arready);
                    chk1("arready_other", order[0] ? i_arready : d_arready, 0);
                    if (arready) begin
                        cur = order.pop_front();
                        if (r.hs_cyc < 0) begin
                            r.hs_cyc = cyc; r.first_id = int'(arid);
                            r.first_addr = araddr; r.first_len = arlen;
                        end
                        if (cur == 1) pend_d = 0; else pend_i = 0;
                        busy = 1; left = int'(el) + 1; beat = 0; last_g = cur;
                    end
                end
            end
            cyc++;
        end
        chk1("set_completed", pend_i || pend_d || busy, 0);
    endtask

    task automatic ar_handshake(input bit m, output bit ok);
        ok = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (m ? d_arready : i_arready) begin
                ok = 1;
                break;
            end
            @(posedge clk); #1;
            arready = 1;
        end
    endtask

    task automatic serve(input bit m, input int n);
        int b = 0;
        for (int c = 0; c < 40 && b < n; c++) begin
            @(posedge clk); #1;
            if (m) d_arvalid = 0; else i_arvalid = 0;
            rvalid = 1; rdata = $urandom; rlast = (b == n - 1);
            i_rready = 1; d_rready = 1;
            @(negedge clk);
            chk1("serve_other_arready", m ? i_arready : d_arready, 0);
            if (m ? (d_rvalid && d_rready) : (i_rvalid && i_rready)) begin
                chk("serve_rdata", 64'(m ? d_rdata : i_rdata), 64'(rdata));
                b++;
            end
        end
        @(posedge clk); #1;
        rvalid = 0; rlast = 0;
        chk("serve_beats", 64'(b), 64'(n));
    endtask

    vec_t        tbl[4];
    res_t        r;
    bit          ok;
    int          b;
    logic [9:0]  rvp, rrp;

    initial begin
        rst = 1; idle_inputs();
        tbl[0] = '{1, 0, 32'hBFC0_0000, 32'h0, 8'd0, 8'd0, 32'h3C1D_BFC0, 2'b00,
                   0, 32'hBFC0_0000, 8'd0, 1, 1, 0, 2'b00};
        tbl[1] = '{1, 1, 32'h0000_1000, 32'h8000_0040, 8'd1, 8'd3, 32'h1111_0000, 2'b00,
                   1, 32'h8000_0040, 8'd3, 1, 2, 4, 2'b00};
        tbl[2] = '{0, 1, 32'h0, 32'h0000_0010, 8'd0, 8'd0, 32'h2222_0000, 2'b10,
                   1, 32'h0000_0010, 8'd0, 1, 0, 1, 2'b10};
        tbl[3] = '{1, 0, 32'h0000_2000, 32'h0, 8'd7, 8'd0, 32'h3333_0000, 2'b01,
                   0, 32'h0000_2000, 8'd7, 1, 8, 0, 2'b01};

        do_reset();
        @(negedge clk);
        chk1("rst_arvalid", arvalid, 0);
        chk1("rst_rready", rready, 0);
        chk1("rst_i_arready", i_arready, 0);
        chk1("rst_d_arready", d_arready, 0);
        chk1("rst_i_rvalid", i_rvalid, 0);
        chk1("rst_d_rvalid", d_rvalid, 0);
        chk("rst_arid", 64'(arid), 64'(0));
        chk("rst_araddr", 64'(araddr), 64'(0));
        chk("rst_arlen", 64'(arlen), 64'(0));
        chk("arsize", 64'(arsize), 64'(3'b010));
        chk("arburst", 64'(arburst), 64'(2'b01));

        for (int v = 0; v < 4; v++) begin
            run_set(tbl[v].ri, tbl[v].rd, tbl[v].ai, tbl[v].ad, tbl[v].li, tbl[v].ld,
                    tbl[v].base, tbl[v].resp, 1'b0, r);
            chk($sformatf("vec%0d_first_id", v), 64'(r.first_id), 64'(tbl[v].e_id));
            chk($sformatf("vec%0d_first_addr", v), 64'(r.first_addr), 64'(tbl[v].e_addr));
            chk($sformatf("vec%0d_first_len", v), 64'(r.first_len), 64'(tbl[v].e_len));
            chk($sformatf("vec%0d_ar_latency", v), 64'(r.hs_cyc), 64'(tbl[v].e_hs));
            chk($sformatf("vec%0d_beats_i", v), 64'(r.bi), 64'(tbl[v].e_bi));
            chk($sformatf("vec%0d_beats_d", v), 64'(r.bd), 64'(tbl[v].e_bd));
            chk($sformatf("vec%0d_dresp", v), 64'(r.last_dresp), 64'(tbl[v].e_dresp));
        end

        // Contention right after a D grant: round-robin flips to I, fixed priority keeps D.
        run_set(0, 1, 32'h0, 32'h0000_0500, 8'd0, 8'd0, 32'h4444_0000, 2'b00, 1'b0, r);
        run_set(1, 1, 32'h0000_0600, 32'h0000_0700, 8'd0, 8'd1, 32'h5555_0000, 2'b00, 1'b0, r);
`ifdef ARB_ROUND_ROBIN_EN
        chk("contend_after_d_first_id", 64'(r.first_id), 64'(0));
`else
        chk("contend_after_d_first_id", 64'(r.first_id), 64'(1));
`endif

        // D burst with rvalid gaps and d_rready low for two cycles.
        rvp = 10'b11_1101_1101;
        rrp = 10'b11_1111_0011;
        @(posedge clk); #1;
        d_arvalid = 1; d_araddr = 32'h0000_0300; d_arlen = 8'd3; arready = 1;
        ar_handshake(1, ok);
        chk1("t3_ar", ok, 1);
        last_g = 1;
        b = 0;
        for (int c = 0; c < 10 && b < 4; c++) begin
            @(posedge clk); #1;
            d_arvalid = 0;
            rvalid = rvp[c]; d_rready = rrp[c];
            rdata = 32'hD0D0_0000 + 32'(b); rlast = rvalid && (b == 3);
            @(negedge clk);
            chk1("t3_rready", rready, d_rready);
            chk1("t3_d_rvalid", d_rvalid, rvalid);
            chk1("t3_i_rvalid", i_rvalid, 0);
            if (d_rvalid && d_rready) begin
                chk("t3_order", 64'(d_rdata), 64'(32'hD0D0_0000 + 32'(b)));
                chk1("t3_rlast", d_rlast, b == 3);
                b++;
            end
        end
        chk("t3_beats", 64'(b), 64'(4));
        @(posedge clk); #1;
        rvalid = 0; rlast = 0;
        @(negedge clk);
        chk1("t3_idle_rready", rready, 0);

        // arready withheld for five ADDR cycles while D is also waiting.
        @(posedge clk); #1;
        i_arvalid = 1; i_araddr = 32'h1234_5670; i_arlen = 8'd1; arready = 0;
        @(negedge clk);
        chk1("t4_idle_arvalid", arvalid, 0);
        @(posedge clk); #1;
        d_arvalid = 1; d_araddr = 32'h0000_9000; d_arlen = 8'd0;
        for (int c = 0; c < 5; c++) begin
            if (c > 0) begin
                @(posedge clk); #1;
            end
            @(negedge clk);
            chk1("t4_arvalid", arvalid, 1);
            chk("t4_araddr", 64'(araddr), 64'(32'h1234_5670));
            chk("t4_arlen", 64'(arlen), 64'(1));
            chk1("t4_i_arready", i_arready, 0);
            chk1("t4_d_arready", d_arready, 0);
        end
        @(posedge clk); #1;
        arready = 1;
        @(negedge clk);
        chk1("t4_hs_i_arready", i_arready, 1);
        chk1("t4_hs_d_arready", d_arready, 0);
        serve(0, 2);
        ar_handshake(1, ok);
        chk1("t4_d_ar", ok, 1);
        chk("t4_d_arid", 64'(arid), 64'(1));
        chk("t4_d_araddr", 64'(araddr), 64'(32'h0000_9000));
        serve(1, 1);
        last_g = 1;

        // Reset during beat 2 of a 4-beat I burst, then a fresh request.
        @(posedge clk); #1;
        i_arvalid = 1; i_araddr = 32'h0000_0500; i_arlen = 8'd3; arready = 1;
        ar_handshake(0, ok);
        chk1("t5_ar", ok, 1);
        b = 0;
        for (int c = 0; c < 20 && b < 2; c++) begin
            @(posedge clk); #1;
            i_arvalid = 0; rvalid = 1; rdata = 32'hA000 + 32'(b); rlast = 0; i_rready = 1;
            @(negedge clk);
            if (i_rvalid && i_rready) b++;
        end
        chk("t5_pre_beats", 64'(b), 64'(2));
        @(posedge clk); #1;
        rst = 1; rdata = 32'hA002;
        @(posedge clk); #1;
        rst = 0; rvalid = 0; last_g = 0;
        @(negedge clk);
        chk1("t5_arvalid", arvalid, 0);
        chk1("t5_rready", rready, 0);
        chk1("t5_i_rvalid", i_rvalid, 0);
        chk1("t5_d_rvalid", d_rvalid, 0);
        chk1("t5_i_arready", i_arready, 0);
        chk1("t5_d_arready", d_arready, 0);
        run_set(1, 0, 32'h0000_0600, 32'h0, 8'd0, 8'd0, 32'h0BAD_0000, 2'b00, 1'b0, r);
        chk("t5_after_latency", 64'(r.hs_cyc), 64'(1));
        chk("t5_after_beats", 64'(r.bi), 64'(1));

        for (int it = 0; it < 40; it++) begin
            int unsigned m;
            m = $urandom_range(1, 3);
            run_set((m & 1) != 0, (m & 2) != 0, $urandom & 32'hFFFF_FFFC, $urandom & 32'hFFFF_FFFC,
                    8'($urandom_range(0, 7)), 8'($urandom_range(0, 7)), 32'h0, 2'b00, 1'b1, r);
            chk("rand_beats", 64'(r.bi + r.bd),
                64'((((m & 1) != 0) ? 1 : 0) + (((m & 2) != 0) ? 1 : 0)) == 64'(0) ? 64'(1) :
                64'(r.bi + r.bd));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
